key_scheduler_rev: RTL and testbench

//   Decryption-side round-key source. Takes the 20-bit master key and

---
 rtl/key_scheduler_rev_pkg.sv | 22 ++
 rtl/key_scheduler_rev_if.sv | 16 +
 rtl/key_scheduler_rev_key_update.sv | 18 +
 rtl/key_scheduler_rev.sv | 120 ++++++++++++
 tb/tb_key_scheduler_rev.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_scheduler_rev_pkg.sv
// Shared constants, FSM state type and the 4-bit substitution box
// used by the forward key step.
package key_scheduler_rev_pkg;
  localparam int KEY_W    = 20;
  localparam int RK_W     = 16;
  localparam int NUM_KEYS = 8;
  localparam int IDX_W    = $clog2(NUM_KEYS);
  localparam int RC_W     = 4;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC; 4'h1: y = 4'h5; 4'h2: y = 4'h6; 4'h3: y = 4'hB;
      4'h4: y = 4'h9; 4'h5: y = 4'h0; 4'h6: y = 4'hA; 4'h7: y = 4'hD;
      4'h8: y = 4'h3; 4'h9: y = 4'hE; 4'hA: y = 4'hF; 4'hB: y = 4'h8;
      4'hC: y = 4'h4; 4'hD: y = 4'h7; 4'hE: y = 4'h1; default: y = 4'h2;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/key_scheduler_rev_if.sv
// Round-key stream. Handshake: a beat transfers on a rising clock edge when
// key_valid and key_ready are both high; while key_valid is high and key_ready
// is low, round_key/round_idx/last hold stable; key_ready is ignored while
// key_valid is low.
interface key_scheduler_rev_if;
  import key_scheduler_rev_pkg::*;

  logic              key_valid;
  logic              key_ready;
  logic [RK_W-1:0]   round_key;
  logic [IDX_W-1:0]  round_idx;
  logic              last;

  modport master (output key_valid, round_key, round_idx, last, input key_ready);
  modport slave  (input key_valid, round_key, round_idx, last, output key_ready);
endinterface

// File: rtl/key_scheduler_rev_key_update.sv
// Forward key step F(k, rc): rotate left by 7, substitute the top nibble,
// fold the round counter into bits [8:5].
module key_update
  import key_scheduler_rev_pkg::*;
(
  input  logic [KEY_W-1:0] key_in,
  input  logic [RC_W-1:0]  rc,
  output logic [KEY_W-1:0] key_out
);
  logic [KEY_W-1:0] rot;

  always_comb begin
    rot            = {key_in[KEY_W-8:0], key_in[KEY_W-1:KEY_W-7]};
    key_out        = rot;
    key_out[19:16] = sbox4(rot[19:16]);
    key_out[8:5]   = rot[8:5] ^ rc;
  end
endmodule

// File: rtl/key_scheduler_rev.sv
// Expands the master key forward into k0..k7, then streams them back out
// k7 first so the inverse cipher rounds can consume them in order.
module key_scheduler_rev
  import key_scheduler_rev_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KEY_W-1:0]    master_key,
  output logic                busy,
  key_scheduler_rev_if.master rk,
  output state_t              dbg_state
);
  state_t             state_q, state_d;
  logic [KEY_W-1:0]   work_q, work_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d, ptr_m1;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [RK_W-1:0]    round_key_q, round_key_d;
  logic [IDX_W-1:0]   round_idx_q, round_idx_d;
  logic [RK_W-1:0]    stack_q [NUM_KEYS];
  logic [RK_W-1:0]    stack_d [NUM_KEYS];
  logic [KEY_W-1:0]   f_out;

  key_update u_key_update (.key_in(work_q), .rc(rc_q), .key_out(f_out));

  assign ptr_m1 = ptr_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rc_d        = rc_q;
    ptr_d       = ptr_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    last_d      = last_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    stack_d     = stack_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d     = master_key;
          stack_d[0] = master_key[KEY_W-1 -: RK_W];
          rc_d       = RC_W'(1);
          busy_d     = 1'b1;
          state_d    = EXPAND;
        end
      end
      EXPAND: begin
        work_d                      = f_out;
        stack_d[rc_q[IDX_W-1:0]]    = f_out[KEY_W-1 -: RK_W];
        rc_d                        = rc_q + 1'b1;
        // k7 comes straight from the step output; its stack slot is written this same edge.
        if (rc_q == RC_W'(NUM_KEYS-1)) begin
          state_d     = EMIT;
          ptr_d       = IDX_W'(NUM_KEYS-1);
          valid_d     = 1'b1;
          round_key_d = f_out[KEY_W-1 -: RK_W];
          round_idx_d = IDX_W'(NUM_KEYS-1);
          last_d      = 1'b0;
        end
      end
      EMIT: begin
        if (valid_q && rk.key_ready) begin
          if (ptr_q != '0) begin
            ptr_d       = ptr_m1;
            round_key_d = stack_q[ptr_m1];
            round_idx_d = ptr_m1;
            last_d      = (ptr_m1 == '0);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      rc_q        <= '0;
      ptr_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      round_key_q <= '0;
      round_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      rc_q        <= rc_d;
      ptr_q       <= ptr_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign busy         = busy_q;
  assign rk.key_valid = valid_q;
  assign rk.round_key = round_key_q;
  assign rk.round_idx = round_idx_q;
  assign rk.last      = last_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_key_scheduler_rev.sv
// Directed bench for key_scheduler_rev: reset, full streams, backpressure,
// start suppression while busy, and mid-run reset.
module tb_key_scheduler_rev;
  import key_scheduler_rev_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] master_key;
  logic        busy;
  state_t      dbg_state;

  key_scheduler_rev_if ks();

  key_scheduler_rev dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .master_key (master_key),
    .busy       (busy),
    .rk         (ks.master),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int start_cyc;
  int first_valid_cyc;

  logic [15:0] exp_q[$];
  logic [15:0] got_key[$];
  logic [2:0]  got_idx[$];
  logic        got_last[$];
  logic [15:0] stall_key[$];
  logic [2:0]  stall_idx[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model of the forward key step.
  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [19:0] ref_step(input logic [19:0] k, input logic [3:0] rc);
    logic [19:0] r;
    r       = {k[12:0], k[19:13]};
    r[19:16] = ref_sbox(r[19:16]);
    r[8:5]  = r[8:5] ^ rc;
    return r;
  endfunction

  // Scoreboard: expected stream order is k7 .. k0.
  task automatic fill_exp(input logic [19:0] key);
    logic [15:0] ks_arr [8];
    logic [19:0] w;
    w = key;
    ks_arr[0] = w[19:4];
    for (int i = 1; i < 8; i++) begin
      w = ref_step(w, 4'(i));
      ks_arr[i] = w[19:4];
    end
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(ks_arr[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [19:0] key);
    start      = 1'b1;
    master_key = key;
    start_cyc  = cyc;
    tick();
    start      = 1'b0;
    master_key = 20'($urandom);
  endtask

  // Consumer driver: records beats, optional 5-cycle stalls on two indices,
  // optional start pokes while valid, optional reset when abort_idx appears.
  task automatic collect(input int budget, input int stall_a, input int stall_b,
                         input bit poke, input logic [19:0] poke_key,
                         input int abort_idx, output bit timed_out);
    int sa;
    int sb;
    bit done;
    got_key.delete(); got_idx.delete(); got_last.delete();
    stall_key.delete(); stall_idx.delete();
    first_valid_cyc = -1;
    sa = 0; sb = 0; done = 1'b0; timed_out = 1'b1;
    for (int c = 0; c < budget && !done; c++) begin
      start        = 1'b0;
      ks.key_ready = 1'b1;
      if (ks.key_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (poke) begin
          start      = 1'b1;
          master_key = poke_key;
        end
        if (int'(ks.round_idx) == abort_idx) begin
          ks.key_ready = 1'b0;
          reset        = 1'b1;
          done         = 1'b1;
          timed_out    = 1'b0;
        end else if (int'(ks.round_idx) == stall_a && sa < 5) begin
          ks.key_ready = 1'b0;
          sa++;
          stall_key.push_back(ks.round_key);
          stall_idx.push_back(ks.round_idx);
        end else if (int'(ks.round_idx) == stall_b && sb < 5) begin
          ks.key_ready = 1'b0;
          sb++;
          stall_key.push_back(ks.round_key);
          stall_idx.push_back(ks.round_idx);
        end else begin
          got_key.push_back(ks.round_key);
          got_idx.push_back(ks.round_idx);
          got_last.push_back(ks.last);
          if (ks.last) begin
            done      = 1'b1;
            timed_out = 1'b0;
          end
        end
      end
      tick();
    end
    start        = 1'b0;
    reset        = 1'b0;
    ks.key_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; master_key = '0; ks.key_ready = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    total++; if (ks.key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ks.key_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (ks.last !== 1'b0) begin bad++; $display("FAIL rst_last got=%b want=0", ks.last); end
    total++; if (ks.round_key !== 16'h0000) begin bad++; $display("FAIL rst_key got=%h want=0000", ks.round_key); end
    total++; if (ks.round_idx !== 3'd0) begin bad++; $display("FAIL rst_idx got=%0d want=0", ks.round_idx); end
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dbg_state, IDLE); end
    ks.key_ready = 1'b1;
    tick(); tick(); tick();
    total++; if (ks.key_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_ready valid=%b busy=%b want 0/0", ks.key_valid, busy);
    end
  endtask

  task automatic test_zero_key();
    bit to;
    logic [15:0] e;
    fill_exp(20'h00000);
    do_start(20'h00000);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b want=1", busy); end
    collect(60, -1, -1, 1'b0, '0, -1, to);
    total++; if (to) begin bad++; $display("FAIL zero_timeout beats=%0d want 8", got_key.size()); end
    total++; if (first_valid_cyc - start_cyc != 8) begin
      bad++; $display("FAIL zero_latency got=%0d want=8", first_valid_cyc - start_cyc);
    end
    total++; if (got_key.size() != 8) begin bad++; $display("FAIL zero_count got=%0d want=8", got_key.size()); end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i) || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL zero_beat%0d key=%h idx=%0d last=%b want key=%h idx=%0d last=%b",
                 i, got_key[i], got_idx[i], got_last[i], e, 7 - i, (i == 7));
      end
    end
    // Hand values: k1 of the all-zero key is C002, k0 is 0000.
    total++; if (got_key.size() == 8 && got_key[6] !== 16'hC002) begin
      bad++; $display("FAIL zero_k1 got=%h want=c002", got_key[6]);
    end
    total++; if (got_key.size() == 8 && got_key[7] !== 16'h0000) begin
      bad++; $display("FAIL zero_k0 got=%h want=0000", got_key[7]);
    end
    total++; if (busy !== 1'b0 || ks.key_valid !== 1'b0 || cyc - start_cyc != 16) begin
      bad++; $display("FAIL zero_done busy=%b valid=%b at=%0d want 0/0 at 16", busy, ks.key_valid, cyc - start_cyc);
    end
  endtask

  task automatic test_ones_key();
    bit to;
    logic [15:0] e;
    fill_exp(20'hFFFFF);
    do_start(20'hFFFFF);
    collect(60, -1, -1, 1'b0, '0, -1, to);
    total++; if (to || got_key.size() != 8) begin
      bad++; $display("FAIL ones_count got=%0d want=8", got_key.size());
    end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i) || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL ones_beat%0d key=%h idx=%0d last=%b want key=%h idx=%0d last=%b",
                 i, got_key[i], got_idx[i], got_last[i], e, 7 - i, (i == 7));
      end
    end
    // Hand values: k1 of FFFFF is 2FFD, k0 is FFFF.
    total++; if (got_key.size() == 8 && got_key[6] !== 16'h2FFD) begin
      bad++; $display("FAIL ones_k1 got=%h want=2ffd", got_key[6]);
    end
    total++; if (got_key.size() == 8 && (got_key[7] !== 16'hFFFF || got_idx[7] !== 3'd0)) begin
      bad++; $display("FAIL ones_k0 key=%h idx=%0d want ffff/0", got_key[7], got_idx[7]);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    logic [15:0] e;
    logic [15:0] k7;
    logic [15:0] k3;
    fill_exp(20'hA5C3E);
    k7 = exp_q[0];
    k3 = exp_q[4];
    do_start(20'hA5C3E);
    collect(80, 7, 3, 1'b0, '0, -1, to);
    total++; if (to || got_key.size() != 8) begin
      bad++; $display("FAIL bp_count got=%0d want=8", got_key.size());
    end
    total++; if (stall_key.size() != 10) begin
      bad++; $display("FAIL bp_stalls got=%0d want=10", stall_key.size());
    end
    for (int i = 0; i < stall_key.size(); i++) begin
      total++;
      if ((i < 5 && (stall_key[i] !== k7 || stall_idx[i] !== 3'd7)) ||
          (i >= 5 && (stall_key[i] !== k3 || stall_idx[i] !== 3'd3))) begin
        bad++;
        $display("FAIL bp_hold%0d key=%h idx=%0d want key=%h", i, stall_key[i], stall_idx[i], (i < 5) ? k7 : k3);
      end
    end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i) || got_last[i] !== (i == 7)) begin
        bad++;
        $display("FAIL bp_beat%0d key=%h idx=%0d last=%b want key=%h idx=%0d", i, got_key[i], got_idx[i], got_last[i], e, 7 - i);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [15:0] e;
    fill_exp(20'h13579);
    do_start(20'h13579);
    start = 1'b1; master_key = 20'hBEEF0;
    tick(); tick(); tick(); tick();
    start = 1'b0;
    collect(60, -1, -1, 1'b1, 20'hBEEF0, -1, to);
    total++; if (to || got_key.size() != 8 || first_valid_cyc - start_cyc != 8) begin
      bad++; $display("FAIL ign_count got=%0d lat=%0d want 8/8", got_key.size(), first_valid_cyc - start_cyc);
    end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i)) begin
        bad++; $display("FAIL ign_beat%0d key=%h idx=%0d want key=%h idx=%0d", i, got_key[i], got_idx[i], e, 7 - i);
      end
    end
    total++; if (busy !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL ign_idle busy=%b state=%0d want 0/IDLE", busy, dbg_state);
    end
    // First IDLE cycle after the last beat: a new run starts immediately.
    fill_exp(20'h2468A);
    do_start(20'h2468A);
    collect(60, -1, -1, 1'b0, '0, -1, to);
    total++; if (to || got_key.size() != 8 || first_valid_cyc - start_cyc != 8) begin
      bad++; $display("FAIL rerun_count got=%0d lat=%0d want 8/8", got_key.size(), first_valid_cyc - start_cyc);
    end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i) || got_last[i] !== (i == 7)) begin
        bad++; $display("FAIL rerun_beat%0d key=%h idx=%0d want key=%h idx=%0d", i, got_key[i], got_idx[i], e, 7 - i);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int spurious;
    logic [15:0] e;
    do_start(20'h0F0F0);
    tick(); tick(); tick();
    total++; if (dbg_state !== EXPAND || busy !== 1'b1) begin
      bad++; $display("FAIL rm_expand state=%0d busy=%b want EXPAND/1", dbg_state, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (ks.key_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
      bad++; $display("FAIL rm_exp_abort valid=%b busy=%b state=%0d want 0/0/IDLE", ks.key_valid, busy, dbg_state);
    end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (ks.key_valid) spurious++;
      tick();
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rm_exp_quiet got=%0d want=0", spurious); end
    do_start(20'h77777);
    collect(60, -1, -1, 1'b0, '0, 5, to);
    total++; if (to || got_key.size() != 2) begin
      bad++; $display("FAIL rm_emit_pre got=%0d want=2", got_key.size());
    end
    total++; if (ks.key_valid !== 1'b0 || busy !== 1'b0 || ks.last !== 1'b0 || ks.round_key !== 16'h0000) begin
      bad++; $display("FAIL rm_emit_abort valid=%b busy=%b last=%b key=%h want 0/0/0/0000", ks.key_valid, busy, ks.last, ks.round_key);
    end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (ks.key_valid) spurious++;
      tick();
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rm_emit_quiet got=%0d want=0", spurious); end
    fill_exp(20'hC0FFE);
    do_start(20'hC0FFE);
    collect(60, -1, -1, 1'b0, '0, -1, to);
    total++; if (to || got_key.size() != 8) begin
      bad++; $display("FAIL rm_after_count got=%0d want=8", got_key.size());
    end
    for (int i = 0; i < got_key.size() && i < 8; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_key[i] !== e || got_idx[i] !== 3'(7 - i) || got_last[i] !== (i == 7)) begin
        bad++; $display("FAIL rm_after_beat%0d key=%h idx=%0d want key=%h idx=%0d", i, got_key[i], got_idx[i], e, 7 - i);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    master_key = '0;
    ks.key_ready = 1'b0;
    test_reset();
    test_zero_key();
    test_ones_key();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
